// File: rtl/mfp_sevenseg_pkg.sv
// Shared definitions for the seven-segment display arbiter family.
package mfp_sevenseg_pkg;

    // Arbiter state encoding; values are fixed so debug taps stay stable.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN0  = 2'd1,
        OWN1  = 2'd2,
        BLANK = 2'd3
    } arb_state_e;

    // Active-low enables: all ones turns every digit off.
    localparam logic [7:0] EN_OFF = 8'hFF;

    // Round-robin pick: a sole requester wins, under contention the port
    // that did not own the display last time wins.
    function automatic logic rr_pick(input logic [1:0] req, input logic last);
        if (req == 2'b11) begin
            return ~last;
        end
        return req[1];
    endfunction

endpackage

// File: rtl/mfp_sevenseg_arb_mux.sv
// Registered 2:1 display source select with forced blanking.
// sel_i/blank_i are the values the outputs should reflect after the next edge.
module mfp_sevenseg_arb_mux
    import mfp_sevenseg_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        sel_i,
    input  logic        blank_i,
    input  logic [7:0]  en0_i,
    input  logic [63:0] digits0_i,
    input  logic [7:0]  dp0_i,
    input  logic [7:0]  en1_i,
    input  logic [63:0] digits1_i,
    input  logic [7:0]  dp1_i,
    output logic [7:0]  en_o,
    output logic [63:0] digits_o,
    output logic [7:0]  dp_o
);

    // Register the selected source live every cycle, or force all-off.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            en_o     <= EN_OFF;
            digits_o <= '0;
            dp_o     <= '0;
        end else if (blank_i) begin
            en_o     <= EN_OFF;
            digits_o <= '0;
            dp_o     <= '0;
        end else if (sel_i) begin
            en_o     <= en1_i;
            digits_o <= digits1_i;
            dp_o     <= dp1_i;
        end else begin
            en_o     <= en0_i;
            digits_o <= digits0_i;
            dp_o     <= dp0_i;
        end
    end

endmodule

// File: rtl/mfp_sevenseg_arbiter.sv
// Time-slicing owner arbiter for the shared 8-digit seven-segment display.
// Port 0 is the CPU register image, port 1 the irrigation readout. Owners
// hold the display for a minimum dwell under contention and a blank gap is
// inserted between owners to avoid ghosting.
module mfp_sevenseg_arbiter
    import mfp_sevenseg_pkg::*;
#(
    parameter int DWELL_CYCLES = 50000000,
    parameter int BLANK_CYCLES = 1000000,
    parameter int CNT_W        = 26
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [1:0]  req,
    input  logic [7:0]  en0,
    input  logic [63:0] digits0,
    input  logic [7:0]  dp0,
    input  logic [7:0]  en1,
    input  logic [63:0] digits1,
    input  logic [7:0]  dp1,
    output logic [1:0]  gnt,
    output logic        busy,
    output logic [7:0]  EN,
    output logic [63:0] DIGITS,
    output logic [7:0]  dp
);

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_q, last_d;
    logic             tgt_q, tgt_d;
    logic             tgt_vld_q, tgt_vld_d;
    logic [1:0]       gnt_q;
    logic             busy_q;
    logic             own_port;
    logic             oth_port;
    logic             pick;

    // Next-state decision; outputs are registered from these values so they
    // track the state register with no extra lag.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        tgt_d     = tgt_q;
        tgt_vld_d = tgt_vld_q;
        own_port  = (state_q == OWN1);
        oth_port  = ~own_port;
        pick      = rr_pick(req, last_q);
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = pick ? OWN1 : OWN0;
                    last_d  = pick;
                    cnt_d   = '0;
                end
            end
            OWN0, OWN1: begin
                if (!req[own_port]) begin
                    // Release ends ownership at once; dwell only limits pre-emption.
                    state_d   = BLANK;
                    cnt_d     = '0;
                    tgt_d     = oth_port;
                    tgt_vld_d = req[oth_port];
                end else if (cnt_q == DWELL_LAST && req[oth_port]) begin
                    state_d   = BLANK;
                    cnt_d     = '0;
                    tgt_d     = oth_port;
                    tgt_vld_d = 1'b1;
                end else if (cnt_q != DWELL_LAST) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    cnt_d     = '0;
                    tgt_vld_d = 1'b0;
                    if (tgt_vld_q && req[tgt_q]) begin
                        state_d = tgt_q ? OWN1 : OWN0;
                        last_d  = tgt_q;
                    end else if (|req) begin
                        // Target withdrew during the gap; fall back to the idle rule.
                        state_d = pick ? OWN1 : OWN0;
                        last_d  = pick;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM registers plus registered grant/busy decoded from the next state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            last_q    <= 1'b1;
            tgt_q     <= 1'b0;
            tgt_vld_q <= 1'b0;
            gnt_q     <= 2'b00;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            tgt_q     <= tgt_d;
            tgt_vld_q <= tgt_vld_d;
            gnt_q     <= {state_d == OWN1, state_d == OWN0};
            busy_q    <= (state_d != IDLE);
        end
    end

    assign gnt  = gnt_q;
    assign busy = busy_q;

    mfp_sevenseg_arb_mux u_mux (
        .clk       (clk),
        .resetn    (resetn),
        .sel_i     (state_d == OWN1),
        .blank_i   (!(state_d == OWN0 || state_d == OWN1)),
        .en0_i     (en0),
        .digits0_i (digits0),
        .dp0_i     (dp0),
        .en1_i     (en1),
        .digits1_i (digits1),
        .dp1_i     (dp1),
        .en_o      (EN),
        .digits_o  (DIGITS),
        .dp_o      (dp)
    );

    // Grant is never shared between the two ports.
    a_gnt_onehot: assert property (@(posedge clk) disable iff (!resetn) $onehot0(gnt));
    // With no owner every digit must be dark.
    a_dark_when_free: assert property (@(posedge clk) disable iff (!resetn) (gnt == 2'b00) |-> (EN == EN_OFF));

endmodule
